// File: rtl/regfile_debug_ctrl_if.sv
// Bundle of the command, response and RegFile debug-port signals around regfile_debug_ctrl.
// master is the controller's view; slave is the view of the front end plus RegFile.
interface regfile_debug_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic [AW-1:0] swaddr;
  logic [DW-1:0] swdata;
  logic          swena;
  logic [DW-1:0] dff;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;

  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; the sender keeps its payload stable while
  // valid is high and ready is low, and never withdraws valid before the transfer.
  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, dff, rsp_ready,
    output cmd_ready, swaddr, swdata, swena, rsp_valid, rsp_addr, rsp_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, dff, rsp_ready,
    input  cmd_ready, swaddr, swdata, swena, rsp_valid, rsp_addr, rsp_data
  );
endinterface

// File: rtl/regfile_debug_ctrl.sv
// Debug-port master for the RegFile: runs READ, WRITE, DUMP and CLEAR commands
// and returns read data over a valid/ready response channel.
module regfile_debug_ctrl #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_debug_ctrl_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAP  = 3'd2,
    RESP    = 3'd3,
    WR      = 3'd4,
    CLR     = 3'd5
  } state_t;

  localparam logic [1:0]    OP_READ  = 2'b00;
  localparam logic [1:0]    OP_WRITE = 2'b01;
  localparam logic [1:0]    OP_DUMP  = 2'b10;
  localparam logic [1:0]    OP_CLEAR = 2'b11;
  localparam logic [AW-1:0] LAST     = AW'(NREGS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] swaddr_q, swaddr_d;
  logic [DW-1:0] swdata_q, swdata_d;
  logic          swena_q, swena_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [AW-1:0] rsp_addr_q, rsp_addr_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          done_q, done_d;
  logic          dump_q, dump_d;
  logic          cmd_ready;

  // The done cycle keeps cmd_ready low, so there is always one idle cycle between commands.
  assign cmd_ready = (state_q == IDLE) && !done_q && !rst;

  always_comb begin
    state_d     = state_q;
    swaddr_d    = swaddr_q;
    swdata_d    = swdata_q;
    swena_d     = swena_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;
    dump_d      = dump_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          case (bus.cmd_op)
            OP_READ: begin
              swaddr_d = bus.cmd_addr;
              dump_d   = 1'b0;
              state_d  = RD_ADDR;
            end
            OP_WRITE: begin
              swaddr_d = bus.cmd_addr;
              swdata_d = bus.cmd_wdata;
              swena_d  = 1'b1;
              state_d  = WR;
            end
            OP_DUMP: begin
              swaddr_d = '0;
              dump_d   = 1'b1;
              state_d  = RD_ADDR;
            end
            OP_CLEAR: begin
              swaddr_d = '0;
              swdata_d = '0;
              swena_d  = 1'b1;
              state_d  = CLR;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        // dff is combinational on swaddr, so it has settled for a full cycle here.
        rsp_data_d  = bus.dff;
        rsp_addr_d  = swaddr_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (dump_q && (swaddr_q != LAST)) begin
            swaddr_d = swaddr_q + AW'(1);
            state_d  = RD_ADDR;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WR: begin
        swena_d = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      CLR: begin
        if (swaddr_q == LAST) begin
          swena_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          swaddr_d = swaddr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      swaddr_q    <= '0;
      swdata_q    <= '0;
      swena_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
      dump_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      swaddr_q    <= swaddr_d;
      swdata_q    <= swdata_d;
      swena_q     <= swena_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
      dump_q      <= dump_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.swaddr    = swaddr_q;
  assign bus.swdata    = swdata_q;
  assign bus.swena     = swena_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// Bench for regfile_debug_ctrl: a behavioural RegFile on the debug port, a
// shadow copy of the expected register contents and a response scoreboard.
module tb_regfile_debug_ctrl;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy, done;
  logic [2:0] dbg_state;

  regfile_debug_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  regfile_debug_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RegFile model and shadow ----------------
  logic [DW-1:0] rf     [NREGS];
  logic [DW-1:0] shadow [NREGS];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i < 6) return DW'(i);
    return {32'h5EED_0000 + 32'(i), 32'h0F0F_0000 + 32'(i)};
  endfunction

  assign bus.dff = rf[bus.swaddr];

  initial begin
    for (int i = 0; i < NREGS; i++) rf[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.swena) rf[bus.swaddr] <= bus.swdata;
    end
  end

  // ---------------- scoreboard ----------------
  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 done_cnt = 0;
  int                 n_rsp    = 0;
  logic [AW+DW-1:0]   exp_q[$];
  logic [AW-1:0]      sw_log[$];
  logic [AW+DW-1:0]   sb_e;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (done) done_cnt++;
        if (bus.swena) sw_log.push_back(bus.swaddr);
        if (bus.rsp_valid && bus.rsp_ready) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check_eq("rsp_unexpected", 1, 0);
          end else begin
            sb_e = exp_q.pop_front();
            check_eq("rsp_addr", bus.rsp_addr, sb_e[AW+DW-1:DW]);
            check_eq("rsp_data", bus.rsp_data, sb_e[DW-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("cmd_accept", ok, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt > d0) break;
    end
    check_eq(tag, done_cnt, d0 + 1);
  endtask

  // ---------------- stimulus ----------------
  int               d0, r0, err;
  bit               found;
  logic [AW-1:0]    ra;
  logic [DW-1:0]    rd;

  initial begin
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) shadow[i] = init_val(i);

    // Reset state, then a reset that aborts a WRITE mid-cycle
    #1 rst = 1'b1;
    #1;
    check_eq("rst_swena", bus.swena, 0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cmd_ready", bus.cmd_ready, 0);
    check_eq("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    send_cmd(OP_WR, 5'd9, 64'h1111_2222_3333_4444);
    check_eq("wr_swena_before_abort", bus.swena, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_swena", bus.swena, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_swaddr", bus.swaddr, 0);
    check_eq("abort_swdata", bus.swdata, 0);
    check_eq("abort_done", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst2", bus.cmd_ready, 1);
    check_eq("abort_no_write", rf[9], shadow[9]);
    check_eq("abort_no_swena_log", sw_log.size(), 0);

    // WRITE 7 then READ 7 with latency and done-pulse checks
    @(posedge clk);
    #1;
    sw_log.delete();
    d0 = done_cnt;
    send_cmd(OP_WR, 5'd7, 64'hDEADBEEF_00C0FFEE);
    shadow[7] = 64'hDEADBEEF_00C0FFEE;
    wait_done(d0, "wr_done");
    check_eq("wr_swena_cycles", sw_log.size(), 1);
    if (sw_log.size() > 0) check_eq("wr_swaddr", sw_log[0], 7);
    check_eq("wr_rf", rf[7], 64'hDEADBEEF_00C0FFEE);

    push_exp(5'd7, 64'hDEADBEEF_00C0FFEE);
    send_cmd(OP_RD, 5'd7, '0);
    @(negedge clk);
    check_eq("rd_lat1", bus.rsp_valid, 0);
    check_eq("rd_busy", busy, 1);
    check_eq("rd_busy_rdy", bus.cmd_ready, 0);
    @(negedge clk);
    check_eq("rd_lat2", bus.rsp_valid, 0);
    @(negedge clk);
    check_eq("rd_lat3", bus.rsp_valid, 1);
    check_eq("rd_addr_direct", bus.rsp_addr, 7);
    check_eq("rd_data_direct", bus.rsp_data, 64'hDEADBEEF_00C0FFEE);
    repeat (3) @(negedge clk);
    check_eq("rd_stall_valid", bus.rsp_valid, 1);
    check_eq("rd_stall_data", bus.rsp_data, 64'hDEADBEEF_00C0FFEE);
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rd_done_pulse", done, 1);
    check_eq("rd_done_rdy", bus.cmd_ready, 0);
    check_eq("rd_valid_dropped", bus.rsp_valid, 0);
    @(negedge clk);
    check_eq("rd_done_low", done, 0);
    check_eq("rd_idle_rdy", bus.cmd_ready, 1);

    // Random WRITE/READ pairs on the upper registers
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      ra = AW'($urandom_range(8, NREGS - 1));
      rd = {$urandom, $urandom};
      d0 = done_cnt;
      send_cmd(OP_WR, ra, rd);
      shadow[ra] = rd;
      wait_done(d0, "rnd_wr_done");
      push_exp(ra, rd);
      bus.rsp_ready = 1'b1;
      d0 = done_cnt;
      send_cmd(OP_RD, ra, '0);
      wait_done(d0, "rnd_rd_done");
      bus.rsp_ready = 1'b0;
    end

    // DUMP with rsp_ready toggling every cycle
    for (int i = 0; i < NREGS; i++) push_exp(AW'(i), shadow[i]);
    r0 = n_rsp;
    d0 = done_cnt;
    send_cmd(OP_DUMP, 5'd20, '0);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1 bus.rsp_ready = ~bus.rsp_ready;
      if (done_cnt > d0) break;
    end
    bus.rsp_ready = 1'b0;
    check_eq("dump_rsp_count", n_rsp - r0, NREGS);
    repeat (5) @(posedge clk);
    #1;
    check_eq("dump_done_once", done_cnt, d0 + 1);
    check_eq("dump_idle", busy, 0);

    // CLEAR then DUMP
    sw_log.delete();
    d0 = done_cnt;
    send_cmd(OP_CLR, 5'd17, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done(d0, "clr_done");
    check_eq("clr_swena_cycles", sw_log.size(), NREGS);
    err = 0;
    for (int i = 0; i < sw_log.size(); i++) if (sw_log[i] != AW'(i)) err++;
    check_eq("clr_addr_order", err, 0);
    check_eq("clr_swena_low", bus.swena, 0);
    for (int i = 0; i < NREGS; i++) shadow[i] = '0;
    for (int i = 0; i < NREGS; i++) push_exp(AW'(i), '0);
    bus.rsp_ready = 1'b1;
    d0 = done_cnt;
    send_cmd(OP_DUMP, 5'd0, '0);
    wait_done(d0, "clr_dump_done");
    bus.rsp_ready = 1'b0;

    // Reset during DUMP while the response for address 12 is pending
    for (int i = 0; i < NREGS; i++) push_exp(AW'(i), '0);
    d0 = done_cnt;
    send_cmd(OP_DUMP, 5'd0, '0);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      if (bus.rsp_valid) begin
        if (bus.rsp_addr == 5'd12) begin
          found = 1'b1;
          break;
        end
        bus.rsp_ready = 1'b1;
      end
    end
    check_eq("abort_reached_addr12", found, 1);
    check_eq("abort_pending", exp_q.size(), NREGS - 12);
    #1 rst = 1'b1;
    #1;
    check_eq("abort_dump_valid", bus.rsp_valid, 0);
    check_eq("abort_dump_busy", busy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("abort_dump_no_done", done_cnt, d0);
    check_eq("abort_dump_no_valid", bus.rsp_valid, 0);
    push_exp(5'd3, '0);
    bus.rsp_ready = 1'b1;
    d0 = done_cnt;
    send_cmd(OP_RD, 5'd3, '0);
    wait_done(d0, "post_abort_rd_done");

    // Command held while busy: second READ accepted only after the first completes
    rd = {$urandom, $urandom};
    d0 = done_cnt;
    send_cmd(OP_WR, 5'd3, rd);
    shadow[3] = rd;
    wait_done(d0, "t6_wr_done");
    push_exp(5'd7, '0);
    push_exp(5'd3, rd);
    d0 = done_cnt;
    send_cmd(OP_RD, 5'd7, '0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_RD;
    bus.cmd_addr  = 5'd3;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) check_eq("busy_cmd_ready", bus.cmd_ready, 0);
      else if (bus.cmd_ready) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("t6_second_accept", found, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    check_eq("t6_first_done_before", done_cnt, d0 + 1);
    wait_done(d0 + 1, "t6_second_done");
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
